// File: rtl/program_counter.sv
// Program counter with a bounded return stack and RUN/HALT/FAULT control.
// The fetch address, state and stack level are all registered; the status
// outputs are decoded from registered state only.
module program_counter #(
    parameter logic [7:0] RESET_ADDR  = 8'h00,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       suspend_cpu,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       call,
    input  logic       ret,
    input  logic       instruction_end_of_program,
    input  logic       instruction_memory_address_exceeded,
    output logic [7:0] instruction_memory_address,
    output logic       pc_halted,
    output logic       pc_fault,
    output logic [3:0] stack_level
);

    localparam int IDX_W = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_addr;
    logic [3:0]       r_level;
    logic [7:0]       r_stack [STACK_DEPTH];

    state_t           w_state_nxt;
    logic [7:0]       w_addr_nxt;
    logic [3:0]       w_level_nxt;
    logic             w_push;
    logic [7:0]       w_addr_inc;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_push_idx;
    logic             w_stack_full;
    logic             w_stack_empty;

    assign w_addr_inc    = r_addr + 8'd1;
    assign w_top_idx     = IDX_W'(r_level - 4'd1);
    assign w_push_idx    = IDX_W'(r_level);
    assign w_stack_full  = (r_level == 4'(STACK_DEPTH));
    assign w_stack_empty = (r_level == 4'd0);

    // State, address and stack level; reset restarts fetch at RESET_ADDR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
            r_addr  <= RESET_ADDR;
            r_level <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Return-stack storage; contents above the level are never read, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && rstn) begin
            r_stack[w_push_idx] <= w_addr_inc;
        end
    end

    // Next-state: memory fault > end of program > ret > call > branch > increment.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_level_nxt = r_level;
        w_push      = 1'b0;
        if (!suspend_cpu && (r_state == ST_RUN)) begin
            if (instruction_memory_address_exceeded) begin
                w_state_nxt = ST_FAULT;
            end else if (instruction_end_of_program) begin
                w_state_nxt = ST_HALT;
            end else if (ret) begin
                if (w_stack_empty) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_addr_nxt  = r_stack[w_top_idx];
                    w_level_nxt = r_level - 4'd1;
                end
            end else if (call) begin
                if (w_stack_full) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_push      = 1'b1;
                    w_addr_nxt  = branch_target;
                    w_level_nxt = r_level + 4'd1;
                end
            end else if (branch_taken) begin
                w_addr_nxt = branch_target;
            end else begin
                w_addr_nxt = w_addr_inc;
            end
        end
    end

    assign instruction_memory_address = r_addr;
    assign pc_halted                  = (r_state == ST_HALT);
    assign pc_fault                   = (r_state == ST_FAULT);
    assign stack_level                = r_level;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a queue-free array model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_program_counter;

    localparam logic [7:0] RESET_ADDR  = 8'h00;
    localparam int         STACK_DEPTH = 4;

    logic       clk;
    logic       rstn;
    logic       suspend_cpu;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       call;
    logic       ret;
    logic       eop;
    logic       exceeded;
    logic [7:0] addr;
    logic       pc_halted;
    logic       pc_fault;
    logic [3:0] stack_level;

    int checks = 0;
    int errors = 0;

    program_counter #(
        .RESET_ADDR (RESET_ADDR),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk                                (clk),
        .rstn                               (rstn),
        .suspend_cpu                        (suspend_cpu),
        .branch_taken                       (branch_taken),
        .branch_target                      (branch_target),
        .call                               (call),
        .ret                                (ret),
        .instruction_end_of_program         (eop),
        .instruction_memory_address_exceeded(exceeded),
        .instruction_memory_address         (addr),
        .pc_halted                          (pc_halted),
        .pc_fault                           (pc_fault),
        .stack_level                        (stack_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 running, 1 halted, 2 faulted.
    logic [7:0] m_addr;
    int         m_mode;
    int         m_lvl;
    logic [7:0] m_stk [0:7];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_addr <= RESET_ADDR;
            m_mode <= 0;
            m_lvl  <= 0;
        end else if (!suspend_cpu && m_mode == 0) begin
            if (exceeded) m_mode <= 2;
            else if (eop) m_mode <= 1;
            else if (ret) begin
                if (m_lvl == 0) m_mode <= 2;
                else begin
                    m_addr <= m_stk[m_lvl-1];
                    m_lvl  <= m_lvl - 1;
                end
            end else if (call) begin
                if (m_lvl == STACK_DEPTH) m_mode <= 2;
                else begin
                    m_stk[m_lvl] <= m_addr + 8'd1;
                    m_addr       <= branch_target;
                    m_lvl        <= m_lvl + 1;
                end
            end else if (branch_taken) m_addr <= branch_target;
            else m_addr <= m_addr + 8'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, after outputs settle.
    always @(posedge clk) begin
        #1;
        chk("model_addr",   32'(addr),        32'(m_addr));
        chk("model_halted", 32'(pc_halted),   32'(m_mode == 1));
        chk("model_fault",  32'(pc_fault),    32'(m_mode == 2));
        chk("model_level",  32'(stack_level), 32'(m_lvl));
        if (pc_halted && pc_fault) chk("halt_fault_exclusive", 32'd1, 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        suspend_cpu = 0; branch_taken = 0; branch_target = 8'h00;
        call = 0; ret = 0; eop = 0; exceeded = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        step(1);
        rstn = 1;
    endtask

    task automatic jump(input logic [7:0] t);
        branch_taken = 1; branch_target = t;
        step(1);
        branch_taken = 0;
    endtask

    initial begin
        clear_inputs();
        rstn = 0;
        #2;
        chk("reset_addr",   32'(addr),        32'h00);
        chk("reset_level",  32'(stack_level), 32'd0);
        chk("reset_flags",  32'({pc_halted, pc_fault}), 32'd0);
        @(negedge clk);
        rstn = 1;

        // Free-running increment with wrap.
        step(1);
        chk("first_incr", 32'(addr), 32'h01);
        step(255);
        chk("wrap_addr",  32'(addr), 32'h00);
        chk("wrap_fault", 32'(pc_fault), 32'd0);
        step(44);
        chk("run300_addr", 32'(addr), 32'h2C);

        // Nested call / return.
        do_reset();
        jump(8'h10);
        chk("jump_10", 32'(addr), 32'h10);
        call = 1; branch_target = 8'h40; step(1); call = 0;
        chk("call1_addr", 32'(addr), 32'h40);
        chk("call1_lvl",  32'(stack_level), 32'd1);
        step(2);
        chk("addr_42", 32'(addr), 32'h42);
        call = 1; branch_target = 8'h80; step(1); call = 0;
        chk("call2_lvl", 32'(stack_level), 32'd2);
        step(1);
        chk("addr_81", 32'(addr), 32'h81);
        ret = 1; step(1); ret = 0;
        chk("ret1_addr", 32'(addr), 32'h43);
        chk("ret1_lvl",  32'(stack_level), 32'd1);
        step(1);
        chk("addr_44", 32'(addr), 32'h44);
        ret = 1; step(1); ret = 0;
        chk("ret2_addr", 32'(addr), 32'h11);
        chk("ret2_lvl",  32'(stack_level), 32'd0);

        // Simultaneous ret/call/branch: ret wins.
        do_reset();
        jump(8'h21);
        call = 1; branch_target = 8'h50; step(1); call = 0;
        ret = 1; call = 1; branch_taken = 1; branch_target = 8'h99;
        step(1);
        clear_inputs();
        chk("prio_addr", 32'(addr), 32'h22);
        chk("prio_lvl",  32'(stack_level), 32'd0);

        // Stack overflow.
        do_reset();
        call = 1; branch_target = 8'h60;
        step(4);
        chk("ovf_lvl4",     32'(stack_level), 32'd4);
        chk("ovf_nofault",  32'(pc_fault), 32'd0);
        step(1);
        chk("ovf_fault", 32'(pc_fault), 32'd1);
        chk("ovf_lvl",   32'(stack_level), 32'd4);
        chk("ovf_addr",  32'(addr), 32'h60);
        call = 0; ret = 1; step(3); ret = 0;
        chk("ovf_ret_ignored", 32'(stack_level), 32'd4);
        chk("ovf_addr_frozen", 32'(addr), 32'h60);

        // Underflow.
        do_reset();
        ret = 1; step(1); ret = 0;
        chk("udf_fault", 32'(pc_fault), 32'd1);
        chk("udf_addr",  32'(addr), 32'h00);

        // End of program and requests ignored while halted.
        do_reset();
        jump(8'h30);
        eop = 1; step(1); eop = 0;
        chk("halt_flag", 32'(pc_halted), 32'd1);
        chk("halt_addr", 32'(addr), 32'h30);
        branch_taken = 1; branch_target = 8'h77; call = 1;
        step(20);
        clear_inputs();
        chk("halt_hold_addr", 32'(addr), 32'h30);
        chk("halt_hold_flag", 32'(pc_halted), 32'd1);
        chk("halt_hold_lvl",  32'(stack_level), 32'd0);

        // Address fault outranks end of program.
        do_reset();
        step(2);
        exceeded = 1; eop = 1; step(1); clear_inputs();
        chk("exc_fault",  32'(pc_fault), 32'd1);
        chk("exc_halted", 32'(pc_halted), 32'd0);
        chk("exc_addr",   32'(addr), 32'h02);

        // Suspend freezes everything; reset still acts asynchronously.
        do_reset();
        step(3);
        chk("pre_susp_addr", 32'(addr), 32'h03);
        suspend_cpu = 1; branch_taken = 1; branch_target = 8'h99;
        step(2);
        eop = 1; step(1); eop = 0;
        step(2);
        chk("susp_addr",   32'(addr), 32'h03);
        chk("susp_halted", 32'(pc_halted), 32'd0);
        rstn = 0;
        #1;
        chk("async_rst_addr", 32'(addr), 32'(RESET_ADDR));
        step(1);
        clear_inputs();
        rstn = 1;
        step(1);
        chk("post_rst_addr",   32'(addr), 32'h01);
        chk("post_rst_halted", 32'(pc_halted), 32'd0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter RESET_ADDR, default 8'h00, address driven after reset.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-stack entries (legal 2..8).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 suspend_cpu  input  1  freeze: state, address, stack held.
REQ-006 branch_taken  input  1  load branch_target this cycle.
REQ-007 branch_target  input  8  jump/call destination.
REQ-008 call  input  1  push return address, jump to branch_target.
REQ-009 ret  input  1  pop return address into PC.
REQ-010 instruction_end_of_program  input  1  end marker from instruction memory.
REQ-011 instruction_memory_address_exceeded  input  1  address fault from instruction memory.
REQ-012 instruction_memory_address  output  8  fetch address (registered).
REQ-013 pc_halted  output  1  high in HALT.
REQ-014 pc_fault  output  1  high in FAULT.
REQ-015 stack_level  output  4  current number of valid stack entries.

Function
REQ-016 FSM states RUN, HALT, FAULT; state and outputs registered, no combinational input-to-output path.
REQ-017 RUN, suspend_cpu=0: next address by priority ret > call > branch_taken > increment; lower-priority requests in the same cycle are ignored.
REQ-018 Increment: address+1 modulo 256; 8'hFF wraps to 8'h00 without fault.
REQ-019 branch_taken: address <= branch_target next edge (one-cycle latency).
REQ-020 call with stack not full: push address+1 (mod 256), address <= branch_target, stack_level+1.
REQ-021 call with stack full (stack_level==STACK_DEPTH): no push, address held, state -> FAULT.
REQ-022 ret with stack not empty: address <= top entry, stack_level-1.
REQ-023 ret with stack empty: address held, state -> FAULT.
REQ-024 Stack is LIFO; entries beyond stack_level are don't-care and not observable.
REQ-025 RUN, instruction_end_of_program=1: state -> HALT, address held; takes priority over REQ-017 requests that cycle.
REQ-026 RUN, instruction_memory_address_exceeded=1: state -> FAULT, address held; priority over REQ-025.
REQ-027 HALT: address, stack held; all requests ignored; exit only via reset.
REQ-028 FAULT: address, stack held; all requests ignored; exit only via reset.
REQ-029 suspend_cpu=1 in any state: no state, address, or stack change, regardless of other inputs; flag inputs sampled that cycle are discarded, not queued.
REQ-030 pc_halted = (state==HALT); pc_fault = (state==FAULT); never both high.

Reset
REQ-031 rstn low: immediately, without clk, instruction_memory_address=RESET_ADDR, state=RUN, stack_level=0, pc_halted=0, pc_fault=0.
REQ-032 Reset mid-call/ret or while suspended: reset wins; all stack contents discarded.
REQ-033 First increment occurs on the first rising edge with rstn high and suspend_cpu low.

Verification
REQ-034 Reset release, no requests, 300 cycles -> address 00,01,...,FF,00,...; no fault at wrap.
REQ-035 At address 10: call target 40; at 42: call target 80; at 81: ret; next ret -> address 40,41,42,80,81,43,...,44; stack_level 0,1,2,1,0.
REQ-036 Same cycle ret=1, call=1, branch_taken=1, stack_level=1 holding 22 -> address 22, stack_level 0; call ignored.
REQ-037 STACK_DEPTH=4, five consecutive calls -> fifth cycle pc_fault=1, stack_level=4, address frozen; later ret ignored.
REQ-038 ret at stack_level 0 -> pc_fault=1 next edge; end_of_program=1 in RUN at address 30 -> pc_halted=1, address stays 30 for 20 cycles despite branch requests.
REQ-039 suspend_cpu=1 for 5 cycles with branch_taken=1 and end_of_program=1 pulsed -> address, state unchanged; rstn pulsed low mid-suspend -> address RESET_ADDR asynchronously.
